// File: rtl/wb_arbiter_if.sv
// Bus bundle between the writeback arbiter and its producers/consumers.
// The master drives ALU/LSU/decode inputs; the slave (the arbiter) drives the rest.
interface wb_arbiter_if;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        lsu_issue_i;
    logic [4:0]  lsu_issue_rd_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        stall_o;
    logic        we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        err_o;

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        output lsu_issue_i, lsu_issue_rd_i,
        output rs1_addr_i, rs2_addr_i,
        input  lsu_ready_o, stall_o, we_o, rd_addr_o, rd_data_o, err_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  lsu_issue_i, lsu_issue_rd_i,
        input  rs1_addr_i, rs2_addr_i,
        output lsu_ready_o, stall_o, we_o, rd_addr_o, rd_data_o, err_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU has priority over a 2-entry load FIFO,
// and a pending-load scoreboard drives the decode stall.
module wb_arbiter (
    input logic        clk,
    input logic        rst,
    wb_arbiter_if.slave bus
);

    logic [4:0]  fifo_rd_q   [2];
    logic [31:0] fifo_data_q [2];
    logic        head_q;
    logic [1:0]  count_q, count_d;
    logic [31:0] pend_q, pend_d;
    logic        we_q, we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;

    logic        lsu_ready;
    logic        push, pop;
    logic        tail;
    logic [4:0]  head_rd;

    assign lsu_ready = (count_q != 2'd2);
    assign push      = bus.lsu_valid_i & lsu_ready;
    // The FIFO is only considered when the ALU is idle; a fresh push is never bypassed.
    assign pop       = ~bus.alu_valid_i & (count_q != 2'd0);
    assign tail      = head_q ^ count_q[0];
    assign head_rd   = fifo_rd_q[head_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        we_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (bus.alu_valid_i) begin
            we_d      = (bus.alu_rd_i != 5'd0);
            rd_addr_d = bus.alu_rd_i;
            rd_data_d = bus.alu_data_i;
        end else if (pop) begin
            we_d      = (head_rd != 5'd0);
            rd_addr_d = head_rd;
            rd_data_d = fifo_data_q[head_q];
        end
    end

    // Clear first, then set, so a same-cycle issue to the popped rd stays pending.
    always_comb begin
        pend_d = pend_q;
        if (pop) begin
            pend_d[head_rd] = 1'b0;
        end
        if (bus.lsu_issue_i && (bus.lsu_issue_rd_i != 5'd0)) begin
            pend_d[bus.lsu_issue_rd_i] = 1'b1;
        end
        err_d = err_q | (bus.lsu_issue_i & pend_q[bus.lsu_issue_rd_i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_rd_q[0]   <= 5'd0;
            fifo_rd_q[1]   <= 5'd0;
            fifo_data_q[0] <= 32'd0;
            fifo_data_q[1] <= 32'd0;
            head_q         <= 1'b0;
            count_q        <= 2'd0;
            pend_q         <= 32'd0;
            we_q           <= 1'b0;
            rd_addr_q      <= 5'd0;
            rd_data_q      <= 32'd0;
            err_q          <= 1'b0;
        end else begin
            if (push) begin
                fifo_rd_q[tail]   <= bus.lsu_rd_i;
                fifo_data_q[tail] <= bus.lsu_data_i;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q   <= count_d;
            pend_q    <= pend_d;
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    assign bus.lsu_ready_o = lsu_ready;
    assign bus.stall_o     = pend_q[bus.rs1_addr_i] | pend_q[bus.rs2_addr_i];
    assign bus.we_o        = we_q;
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.rd_data_o   = rd_data_q;
    assign bus.err_o       = err_q;

endmodule
